ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage_if.sv | 44 ++++
 rtl/ex_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_ex_stage.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX inputs, the stall back to the issuing stage, and the
// EX/MEM register outputs of the execute stage.
interface ex_stage_if;
  logic        in_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] imm;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic [31:0] fwd_mem;
  logic [31:0] fwd_wb;
  logic [3:0]  ALUop;
  logic        ALUsrc;
  logic [3:0]  D;
  logic        RegWrite;
  logic        RegInsrc;
  logic        DataRead;
  logic        DataWrite;

  logic        stall_out;
  logic        valid_out;
  logic [3:0]  D_out;
  logic        RegWrite_out;
  logic        RegInsrc_out;
  logic        DataRead_out;
  logic        DataWrite_out;
  logic [31:0] data_out;
  logic [7:0]  addr_out;
  logic [31:0] store_out;

  modport master (
    output in_valid, A, B, imm, fwd_a_sel, fwd_b_sel, fwd_mem, fwd_wb,
           ALUop, ALUsrc, D, RegWrite, RegInsrc, DataRead, DataWrite,
    input  stall_out, valid_out, D_out, RegWrite_out, RegInsrc_out,
           DataRead_out, DataWrite_out, data_out, addr_out, store_out
  );

  modport slave (
    input  in_valid, A, B, imm, fwd_a_sel, fwd_b_sel, fwd_mem, fwd_wb,
           ALUop, ALUsrc, D, RegWrite, RegInsrc, DataRead, DataWrite,
    output stall_out, valid_out, D_out, RegWrite_out, RegInsrc_out,
           DataRead_out, DataWrite_out, data_out, addr_out, store_out
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage with operand forwarding, single-cycle ALU and the
// EX/MEM pipeline register.
// Optional macro EX_MUL_EN builds a 32-cycle shift-add multiplier (ALUop 1000)
// that stalls the issuing stage; without it ALUop 1000 yields 0 in one cycle.
//
// Multiplier FSM (EX_MUL_EN only):
//   state | meaning
//   IDLE  | normal issue; a valid MUL latches operands and starts
//   BUSY  | one shift-add step per cycle, count 0..31, stall held high
//   DONE  | product written to EX/MEM with the held D/control bits
module ex_stage (
  input  logic      clk,
  input  logic      rst_n,
  ex_stage_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  logic [31:0] op1;
  logic [31:0] op_b;
  logic [31:0] op2;
  logic [31:0] alu_res;
  logic        stall;
  logic        load_alu;
  logic        load_mul;
  logic [31:0] mul_res;
  logic [31:0] mul_store;
  logic [3:0]  mul_d;
  logic        mul_rw;
  logic        mul_ris;
  logic        mul_dr;
  logic        mul_dw;

  // operand forwarding muxes; selector 11 falls back to the register value
  always_comb begin
    case (bus.fwd_a_sel)
      2'b01:   op1 = bus.fwd_mem;
      2'b10:   op1 = bus.fwd_wb;
      default: op1 = bus.A;
    endcase
    case (bus.fwd_b_sel)
      2'b01:   op_b = bus.fwd_mem;
      2'b10:   op_b = bus.fwd_wb;
      default: op_b = bus.B;
    endcase
    op2 = bus.ALUsrc ? bus.imm : op_b;
  end

  // single-cycle ALU; MUL and undefined codes give 0 here
  always_comb begin
    alu_res = '0;
    case (bus.ALUop)
      OP_ADD:  alu_res = op1 + op2;
      OP_SUB:  alu_res = op1 - op2;
      OP_AND:  alu_res = op1 & op2;
      OP_OR:   alu_res = op1 | op2;
      OP_XOR:  alu_res = op1 ^ op2;
      OP_SLL:  alu_res = op1 << op2[4:0];
      OP_SRL:  alu_res = op1 >> op2[4:0];
      OP_SLT:  alu_res = {31'd0, $signed(op1) < $signed(op2)};
      default: alu_res = '0;
    endcase
  end

`ifdef EX_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q;
  state_t      state_d;
  logic [4:0]  count_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [31:0] acc_q;
  logic [31:0] store_q;
  logic [3:0]  d_q;
  logic        rw_q;
  logic        ris_q;
  logic        dr_q;
  logic        dw_q;
  logic        is_mul;
  logic        mul_start;

  assign is_mul = (bus.ALUop == OP_MUL);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state, stall and EX/MEM load selects
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    mul_start = 1'b0;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && is_mul) begin
          state_d   = BUSY;
          stall     = 1'b1;
          mul_start = 1'b1;
        end else begin
          load_alu = bus.in_valid;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (count_q == 5'd31) state_d = DONE;
      end
      DONE: begin
        state_d  = IDLE;
        load_mul = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // shift-add datapath; instruction fields are held so DONE ignores the bus
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      store_q  <= '0;
      d_q      <= '0;
      rw_q     <= 1'b0;
      ris_q    <= 1'b0;
      dr_q     <= 1'b0;
      dw_q     <= 1'b0;
    end else if (mul_start) begin
      count_q  <= '0;
      mcand_q  <= op1;
      mplier_q <= op2;
      acc_q    <= '0;
      store_q  <= op_b;
      d_q      <= bus.D;
      rw_q     <= bus.RegWrite;
      ris_q    <= bus.RegInsrc;
      dr_q     <= bus.DataRead;
      dw_q     <= bus.DataWrite;
    end else if (state_q == BUSY) begin
      count_q  <= count_q + 5'd1;
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  assign mul_res   = acc_q;
  assign mul_store = store_q;
  assign mul_d     = d_q;
  assign mul_rw    = rw_q;
  assign mul_ris   = ris_q;
  assign mul_dr    = dr_q;
  assign mul_dw    = dw_q;
`else
  assign stall     = 1'b0;
  assign load_alu  = bus.in_valid;
  assign load_mul  = 1'b0;
  assign mul_res   = '0;
  assign mul_store = '0;
  assign mul_d     = '0;
  assign mul_rw    = 1'b0;
  assign mul_ris   = 1'b0;
  assign mul_dr    = 1'b0;
  assign mul_dw    = 1'b0;
`endif

  assign bus.stall_out = stall;

  // EX/MEM register: ALU result, multiplier product, or a bubble that keeps data fields
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.valid_out     <= 1'b0;
      bus.D_out         <= '0;
      bus.RegWrite_out  <= 1'b0;
      bus.RegInsrc_out  <= 1'b0;
      bus.DataRead_out  <= 1'b0;
      bus.DataWrite_out <= 1'b0;
      bus.data_out      <= '0;
      bus.addr_out      <= '0;
      bus.store_out     <= '0;
    end else if (load_mul) begin
      bus.valid_out     <= 1'b1;
      bus.D_out         <= mul_d;
      bus.RegWrite_out  <= mul_rw;
      bus.RegInsrc_out  <= mul_ris;
      bus.DataRead_out  <= mul_dr;
      bus.DataWrite_out <= mul_dw;
      bus.data_out      <= mul_res;
      bus.addr_out      <= mul_res[7:0];
      bus.store_out     <= mul_store;
    end else if (load_alu) begin
      bus.valid_out     <= 1'b1;
      bus.D_out         <= bus.D;
      bus.RegWrite_out  <= bus.RegWrite;
      bus.RegInsrc_out  <= bus.RegInsrc;
      bus.DataRead_out  <= bus.DataRead;
      bus.DataWrite_out <= bus.DataWrite;
      bus.data_out      <= alu_res;
      bus.addr_out      <= alu_res[7:0];
      bus.store_out     <= op_b;
    end else begin
      bus.valid_out     <= 1'b0;
      bus.RegWrite_out  <= 1'b0;
      bus.DataRead_out  <= 1'b0;
      bus.DataWrite_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vector table for the ALU/forwarding paths plus
// hand-written sequences for reset, bubbles and (with EX_MUL_EN) the multiplier.
module tb_ex_stage;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  ex_stage_if bus();

  ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic        vld;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        src;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] fmem;
    logic [31:0] fwb;
    logic [3:0]  d;
    logic        rw;
    logic        ris;
    logic        dr;
    logic        dw;
    logic [31:0] e_data;
    logic [31:0] e_store;
    logic [3:0]  e_d;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic [3:0] op, logic vld, logic [31:0] a, logic [31:0] b,
                              logic [31:0] imm, logic src, logic [1:0] fa, logic [1:0] fb,
                              logic [31:0] fmem, logic [31:0] fwb, logic [3:0] d,
                              logic rw, logic ris, logic dr, logic dw,
                              logic [31:0] e_data, logic [31:0] e_store, logic [3:0] e_d);
    vec_t v;
    v.op = op; v.vld = vld; v.a = a; v.b = b; v.imm = imm; v.src = src;
    v.fa = fa; v.fb = fb; v.fmem = fmem; v.fwb = fwb; v.d = d;
    v.rw = rw; v.ris = ris; v.dr = dr; v.dw = dw;
    v.e_data = e_data; v.e_store = e_store; v.e_d = e_d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid  = v.vld;
    bus.ALUop     = v.op;
    bus.A         = v.a;
    bus.B         = v.b;
    bus.imm       = v.imm;
    bus.ALUsrc    = v.src;
    bus.fwd_a_sel = v.fa;
    bus.fwd_b_sel = v.fb;
    bus.fwd_mem   = v.fmem;
    bus.fwd_wb    = v.fwb;
    bus.D         = v.d;
    bus.RegWrite  = v.rw;
    bus.RegInsrc  = v.ris;
    bus.DataRead  = v.dr;
    bus.DataWrite = v.dw;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " valid"}, {31'd0, bus.valid_out}, 32'd0);
    chk({tag, " data"},  bus.data_out, 32'd0);
    chk({tag, " addr"},  {24'd0, bus.addr_out}, 32'd0);
    chk({tag, " store"}, bus.store_out, 32'd0);
    chk({tag, " D"},     {28'd0, bus.D_out}, 32'd0);
    chk({tag, " ctrl"},  {28'd0, bus.RegWrite_out, bus.RegInsrc_out,
                          bus.DataRead_out, bus.DataWrite_out}, 32'd0);
  endtask

  task automatic do_add(input string tag);
    drive(mk(4'b0000, 1'b1, 32'd5, 32'd7, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0,
             4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0));
    #1;
    chk({tag, " stall"}, {31'd0, bus.stall_out}, 32'd0);
    step();
    chk({tag, " data"},  bus.data_out, 32'd12);
    chk({tag, " D"},     {28'd0, bus.D_out}, 32'd3);
    chk({tag, " valid"}, {31'd0, bus.valid_out}, 32'd1);
    chk({tag, " rw"},    {31'd0, bus.RegWrite_out}, 32'd1);
  endtask

  task automatic bubble();
    bus.in_valid = 1'b0;
    step();
  endtask

`ifdef EX_MUL_EN
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src, input logic [31:0] e_prod);
    int n;
    int bad_valid;
    drive(mk(4'b1000, 1'b1, a, b, imm, src, 2'b00, 2'b00, 32'd0, 32'd0,
             4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 4'd0));
    #1;
    n = 0;
    bad_valid = 0;
    while (bus.stall_out && n < 40) begin
      n++;
      if (bus.valid_out !== 1'b0) bad_valid++;
      step();
    end
    chk({tag, " stall cycles"}, n, 33);
    chk({tag, " valid during stall"}, bad_valid, 0);
    chk({tag, " valid before done edge"}, {31'd0, bus.valid_out}, 32'd0);
    bus.A = 32'hDEAD_BEEF;
    bus.D = 4'd9;
    step();
    chk({tag, " product"}, bus.data_out, e_prod);
    chk({tag, " addr"},    {24'd0, bus.addr_out}, {24'd0, e_prod[7:0]});
    chk({tag, " store"},   bus.store_out, b);
    chk({tag, " valid"},   {31'd0, bus.valid_out}, 32'd1);
    chk({tag, " D"},       {28'd0, bus.D_out}, 32'd5);
    chk({tag, " ctrl"},    {28'd0, bus.RegWrite_out, bus.RegInsrc_out,
                            bus.DataRead_out, bus.DataWrite_out}, 32'hD);
    bubble();
  endtask
`endif

  initial begin
    logic exp_ris;
    n_cmp = 0;
    n_err = 0;
    exp_ris = 1'b0;

    vecs[0]  = mk(4'b0000, 1, 32'd5, 32'd7, 32'd0, 0, 2'b00, 2'b00, 32'd0, 32'd0,
                  4'd3, 1, 0, 0, 0, 32'd12, 32'd7, 4'd3);
    vecs[1]  = mk(4'b0001, 1, 32'h0000_DEAD, 32'h22, 32'hFFFF_FFFF, 1, 2'b01, 2'b00,
                  32'h100, 32'd0, 4'd5, 1, 0, 0, 0, 32'h101, 32'h22, 4'd5);
    vecs[2]  = mk(4'b0010, 1, 32'hF0F0_1234, 32'h5, 32'd0, 0, 2'b00, 2'b10,
                  32'd0, 32'h0FF0_FF00, 4'd1, 0, 1, 0, 1, 32'h00F0_1200, 32'h0FF0_FF00, 4'd1);
    vecs[3]  = mk(4'b0011, 1, 32'h1200_0000, 32'h34, 32'd0, 0, 2'b00, 2'b11,
                  32'hAAAA_AAAA, 32'd0, 4'd2, 1, 0, 0, 0, 32'h1200_0034, 32'h34, 4'd2);
    vecs[4]  = mk(4'b0100, 1, 32'hFFFF_0000, 32'h9, 32'h0F0F_0F0F, 1, 2'b00, 2'b00,
                  32'd0, 32'd0, 4'd4, 0, 0, 1, 0, 32'hF0F0_0F0F, 32'h9, 4'd4);
    vecs[5]  = mk(4'b0101, 1, 32'h3, 32'd0, 32'hFFFF_FFE4, 1, 2'b00, 2'b00,
                  32'd0, 32'd0, 4'd6, 1, 0, 0, 0, 32'h30, 32'd0, 4'd6);
    vecs[6]  = mk(4'b0110, 1, 32'h8000_0000, 32'h1F, 32'd0, 0, 2'b00, 2'b00,
                  32'd0, 32'd0, 4'd7, 1, 0, 0, 0, 32'd1, 32'h1F, 4'd7);
    vecs[7]  = mk(4'b0111, 1, 32'hFFFF_FFFE, 32'd0, 32'd1, 1, 2'b00, 2'b00,
                  32'd0, 32'd0, 4'd8, 1, 0, 0, 0, 32'd1, 32'd0, 4'd8);
    vecs[8]  = mk(4'b0111, 1, 32'd5, 32'hFFFF_FFFF, 32'd0, 0, 2'b00, 2'b00,
                  32'd0, 32'd0, 4'd9, 1, 0, 0, 0, 32'd0, 32'hFFFF_FFFF, 4'd9);
    vecs[9]  = mk(4'b0000, 0, 32'd1, 32'd1, 32'd0, 0, 2'b00, 2'b00,
                  32'd0, 32'd0, 4'd15, 1, 1, 1, 1, 32'd0, 32'hFFFF_FFFF, 4'd9);
    vecs[10] = mk(4'b1001, 1, 32'd3, 32'd4, 32'd0, 0, 2'b00, 2'b00,
                  32'd0, 32'd0, 4'd10, 1, 0, 0, 0, 32'd0, 32'd4, 4'd10);
    vecs[11] = mk(4'b0001, 1, 32'd0, 32'd1, 32'd0, 0, 2'b00, 2'b00,
                  32'd0, 32'd0, 4'd11, 1, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 4'd11);
    vecs[12] = mk(4'b0000, 1, 32'hFFFF_FFFF, 32'd2, 32'd0, 0, 2'b00, 2'b00,
                  32'd0, 32'd0, 4'd12, 1, 0, 0, 0, 32'd1, 32'd2, 4'd12);
    vecs[13] = mk(4'b0000, 1, 32'd7, 32'd8, 32'd0, 0, 2'b11, 2'b11,
                  32'h111, 32'h222, 4'd13, 1, 0, 0, 0, 32'd15, 32'd8, 4'd13);
    vecs[14] = mk(4'b0001, 1, 32'h999, 32'h777, 32'd0, 0, 2'b10, 2'b01,
                  32'd3, 32'h40, 4'd14, 1, 0, 0, 0, 32'h3D, 32'd3, 4'd14);
    vecs[15] = mk(4'b1111, 1, 32'd9, 32'd9, 32'd0, 0, 2'b00, 2'b00,
                  32'd0, 32'd0, 4'd0, 0, 0, 0, 0, 32'd0, 32'd9, 4'd0);

    rst_n = 1'b0;
    drive(mk(4'b0000, 0, 32'd0, 32'd0, 32'd0, 0, 2'b00, 2'b00, 32'd0, 32'd0,
             4'd0, 0, 0, 0, 0, 32'd0, 32'd0, 4'd0));
    step();
    step();
    rst_n = 1'b1;
    chk("reset stall", {31'd0, bus.stall_out}, 32'd0);
    chk_zero("reset");

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d stall", i), {31'd0, bus.stall_out}, 32'd0);
      step();
      if (vecs[i].vld) exp_ris = vecs[i].ris;
      chk($sformatf("v%0d data", i),  bus.data_out, vecs[i].e_data);
      chk($sformatf("v%0d addr", i),  {24'd0, bus.addr_out}, {24'd0, vecs[i].e_data[7:0]});
      chk($sformatf("v%0d store", i), bus.store_out, vecs[i].e_store);
      chk($sformatf("v%0d D", i),     {28'd0, bus.D_out}, {28'd0, vecs[i].e_d});
      chk($sformatf("v%0d valid", i), {31'd0, bus.valid_out}, {31'd0, vecs[i].vld});
      chk($sformatf("v%0d rw", i),    {31'd0, bus.RegWrite_out}, {31'd0, vecs[i].vld & vecs[i].rw});
      chk($sformatf("v%0d ris", i),   {31'd0, bus.RegInsrc_out}, {31'd0, exp_ris});
      chk($sformatf("v%0d dr", i),    {31'd0, bus.DataRead_out}, {31'd0, vecs[i].vld & vecs[i].dr});
      chk($sformatf("v%0d dw", i),    {31'd0, bus.DataWrite_out}, {31'd0, vecs[i].vld & vecs[i].dw});
    end
    bubble();

`ifdef EX_MUL_EN
    run_mul("mul1", 32'h0001_0000, 32'h0003_0001, 32'd0, 1'b0, 32'h0001_0000);
    run_mul("mul2", 32'hFFFF_FFFF, 32'h55, 32'hFFFF_FFFF, 1'b1, 32'd1);
    do_add("add after mul");
    bubble();

    drive(mk(4'b1000, 1, 32'd3, 32'd4, 32'd0, 0, 2'b00, 2'b00, 32'd0, 32'd0,
             4'd7, 1, 1, 1, 1, 32'd0, 32'd0, 4'd0));
    for (int k = 0; k < 11; k++) step();
    chk("busy before reset stall", {31'd0, bus.stall_out}, 32'd1);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b1;
`else
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    step();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
`endif
    chk("post reset stall", {31'd0, bus.stall_out}, 32'd0);
    chk_zero("post reset");
    do_add("add after reset");

`ifndef EX_MUL_EN
    begin
      int stall_seen;
      stall_seen = 0;
      for (int k = 0; k < 3; k++) begin
        drive(mk(4'b1000, 1, 32'd3, 32'd6, 32'd0, 0, 2'b00, 2'b00, 32'd0, 32'd0,
                 4'd1, 1, 0, 0, 0, 32'd0, 32'd0, 4'd0));
        #1;
        if (bus.stall_out !== 1'b0) stall_seen++;
        step();
        chk($sformatf("nomul%0d data", k),  bus.data_out, 32'd0);
        chk($sformatf("nomul%0d valid", k), {31'd0, bus.valid_out}, 32'd1);
        chk($sformatf("nomul%0d store", k), bus.store_out, 32'd6);
      end
      chk("nomul stall seen", stall_seen, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
